// File: rtl/rc4_decrypt_stream.sv
`default_nettype none
// ============================================================================
// Module   : rc4_decrypt_stream
// Purpose  : RC4 PRGA loop of the key cracker. Generates the keystream from
//            the KSA-permuted S-memory and XORs it with the encrypted ROM.
//            Each plaintext byte is written to the decrypted RAM and offered
//            to the character checker over a new_char/compared_char
//            handshake. The checker's start_over aborts the run.
// Options  : `define RC4_HS_TIMEOUT_EN adds a handshake timeout on OFFER
//            (TIMEOUT_CYC parameter, hs_timeout output).
// Revision : 1.0 - initial release
// ============================================================================
module rc4_decrypt_stream #(
    parameter int MSG_LEN     = 32
`ifdef RC4_HS_TIMEOUT_EN
   ,parameter int TIMEOUT_CYC = 1024
`endif
) (
    input  logic       clk,
    input  logic       resetm,
    input  logic       start,
    input  logic       start_over,
    input  logic       compared_char,
    output logic [7:0] s_addr,
    output logic [7:0] s_wdata,
    output logic       s_wren,
    input  logic [7:0] s_q,
    output logic [4:0] rom_addr,
    input  logic [7:0] rom_q,
    output logic [4:0] dec_addr,
    output logic [7:0] dec_wdata,
    output logic       dec_wren,
    output logic       new_char,
    output logic [7:0] char_out,
    output logic [5:0] char_count,
`ifdef RC4_HS_TIMEOUT_EN
    output logic       hs_timeout,
`endif
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_RD_SI  = 4'd1,
        ST_WT_SI  = 4'd2,
        ST_CAP_SI = 4'd3,
        ST_WT_SJ  = 4'd4,
        ST_CAP_SJ = 4'd5,
        ST_WR_SI  = 4'd6,
        ST_WR_SJ  = 4'd7,
        ST_RD_F   = 4'd8,
        ST_WT_F   = 4'd9,
        ST_XOR_WR = 4'd10,
        ST_OFFER  = 4'd11,
        ST_NEXT   = 4'd12,
        ST_DONE   = 4'd13
    } state_t;

    state_t     state_q;
    logic [7:0] i_q, j_q, si_q, sj_q;
    logic [5:0] k_q;

    logic [7:0] s_addr_q, s_wdata_q, dec_wdata_q, char_out_q;
    logic [4:0] rom_addr_q, dec_addr_q;
    logic       s_wren_q, dec_wren_q, new_char_q, busy_q, done_q;

    // Next-state helper values for the index arithmetic (all 8-bit wrap)
    logic [7:0] i_d, j_d, f_addr_d, plain_d;
    logic [5:0] k_d;

`ifdef RC4_HS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] to_cnt_q;
    logic            hs_timeout_q;
    assign hs_timeout = hs_timeout_q;
`endif

    assign i_d      = i_q + 8'd1;
    assign j_d      = j_q + s_q;
    assign f_addr_d = si_q + sj_q;
    assign plain_d  = s_q ^ rom_q;
    assign k_d      = k_q + 6'd1;

    // PRGA sequencer: one byte per pass RD_SI..NEXT, all outputs registered
    always_ff @(posedge clk or negedge resetm) begin
        if (!resetm) begin
            state_q     <= ST_IDLE;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            si_q        <= 8'd0;
            sj_q        <= 8'd0;
            k_q         <= 6'd0;
            s_addr_q    <= 8'd0;
            s_wdata_q   <= 8'd0;
            s_wren_q    <= 1'b0;
            rom_addr_q  <= 5'd0;
            dec_addr_q  <= 5'd0;
            dec_wdata_q <= 8'd0;
            dec_wren_q  <= 1'b0;
            new_char_q  <= 1'b0;
            char_out_q  <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef RC4_HS_TIMEOUT_EN
            to_cnt_q     <= '0;
            hs_timeout_q <= 1'b0;
`endif
        end else begin
            // Write enables are single-cycle pulses unless re-armed below
            s_wren_q   <= 1'b0;
            dec_wren_q <= 1'b0;
`ifdef RC4_HS_TIMEOUT_EN
            hs_timeout_q <= 1'b0;
`endif
            if (start_over) begin
                // Abort wins over every other input this cycle
                state_q    <= ST_IDLE;
                new_char_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b0;
                k_q        <= 6'd0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            i_q     <= 8'd0;
                            j_q     <= 8'd0;
                            k_q     <= 6'd0;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= ST_RD_SI;
                        end
                    end
                    ST_RD_SI: begin
                        i_q      <= i_d;
                        s_addr_q <= i_d;
                        state_q  <= ST_WT_SI;
                    end
                    ST_WT_SI:  state_q <= ST_CAP_SI;
                    ST_CAP_SI: begin
                        si_q     <= s_q;
                        j_q      <= j_d;
                        s_addr_q <= j_d;
                        state_q  <= ST_WT_SJ;
                    end
                    ST_WT_SJ:  state_q <= ST_CAP_SJ;
                    ST_CAP_SJ: begin
                        // Arm the S[i] <= S[j] write for the WR_SI cycle
                        sj_q      <= s_q;
                        s_addr_q  <= i_q;
                        s_wdata_q <= s_q;
                        s_wren_q  <= 1'b1;
                        state_q   <= ST_WR_SI;
                    end
                    ST_WR_SI: begin
                        // Arm the S[j] <= old S[i] write for the WR_SJ cycle
                        s_addr_q  <= j_q;
                        s_wdata_q <= si_q;
                        s_wren_q  <= 1'b1;
                        state_q   <= ST_WR_SJ;
                    end
                    ST_WR_SJ: begin
                        s_addr_q   <= f_addr_d;
                        rom_addr_q <= k_q[4:0];
                        state_q    <= ST_RD_F;
                    end
                    ST_RD_F:   state_q <= ST_WT_F;
                    ST_WT_F: begin
                        char_out_q  <= plain_d;
                        dec_addr_q  <= k_q[4:0];
                        dec_wdata_q <= plain_d;
                        dec_wren_q  <= 1'b1;
                        state_q     <= ST_XOR_WR;
                    end
                    ST_XOR_WR: begin
                        new_char_q <= 1'b1;
`ifdef RC4_HS_TIMEOUT_EN
                        to_cnt_q   <= '0;
`endif
                        state_q    <= ST_OFFER;
                    end
                    ST_OFFER: begin
                        if (compared_char) begin
                            new_char_q <= 1'b0;
                            state_q    <= ST_NEXT;
                        end
`ifdef RC4_HS_TIMEOUT_EN
                        else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                            hs_timeout_q <= 1'b1;
                            new_char_q   <= 1'b0;
                            busy_q       <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
`endif
                    end
                    ST_NEXT: begin
                        k_q <= k_d;
                        if (k_d == 6'(MSG_LEN)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RD_SI;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;
    assign s_wren     = s_wren_q;
    assign rom_addr   = rom_addr_q;
    assign dec_addr   = dec_addr_q;
    assign dec_wdata  = dec_wdata_q;
    assign dec_wren   = dec_wren_q;
    assign new_char   = new_char_q;
    assign char_out   = char_out_q;
    assign char_count = k_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire
